// File: rtl/instr_cycle_sequencer.sv
// rtl/instr_cycle_sequencer.sv - fetch/decode/execute sequencer for the 8-bit accumulator CPU
//
// Purpose: steps each instruction through FETCH, DECODE, EXEC, an optional MEM
// phase and WB. It latches the instruction word into IR and gates the
// combinational Control decoder enables so that each one fires in exactly one
// cycle. It also provides run/step/halt control and a retired-instruction counter.
//
// Ports:
//   clk, rst_n          clock (rising edge); asynchronous active-low reset
//   run, step           free-run level; single-instruction pulse, accepted only in IDLE
//   instr_in            memory data, sampled on the last FETCH cycle
//   dec_*               Control decoder outputs for the latched opcode
//   acc_zero            accumulator == 0, qualifies branches
//   ir_opcode, ir_imm   IR[7:5] and IR[4:0]
//   addr_sel            0 = PC address, 1 = data address
//   pc_en, brnch_yes    PC advance strobe and PC branch-load strobe
//   regWE, accWE, memWE gated write enables
//   halted, state       HALT indicator and debug view of the state
//   instr_count         retired instructions; wraps at 16'hFFFF
module instr_cycle_sequencer #(
   parameter int          MEM_WAIT   = 2,
   parameter int          WAIT_W     = 2,
   parameter logic [7:0]  HALT_INSTR = 8'hFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        step,
   input  logic [7:0]  instr_in,
   input  logic        dec_regWE,
   input  logic        dec_accWE,
   input  logic        dec_memWE,
   input  logic        dec_lw,
   input  logic        dec_brnch,
   input  logic        acc_zero,
   output logic [2:0]  ir_opcode,
   output logic [4:0]  ir_imm,
   output logic        addr_sel,
   output logic        pc_en,
   output logic        brnch_yes,
   output logic        regWE,
   output logic        accWE,
   output logic        memWE,
   output logic        halted,
   output logic [2:0]  state,
   output logic [15:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         ir_q;
   logic [WAIT_W-1:0]  wait_q;
   logic               step_mode_q;
   logic [15:0]        count_q;
   logic               last_wait;

   // FETCH and MEM share one wait counter; the final cycle of an access is count == MEM_WAIT.
   assign last_wait = (wait_q == WAIT_W'(MEM_WAIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ir_q        <= 8'h00;
         wait_q      <= '0;
         step_mode_q <= 1'b0;
         count_q     <= 16'h0000;
      end else begin
         state_q <= state_d;
         if (state_q == S_FETCH && last_wait)
            ir_q <= instr_in;
         if (state_q == S_FETCH || state_q == S_MEM)
            wait_q <= last_wait ? '0 : wait_q + WAIT_W'(1);
         else
            wait_q <= '0;
         if (state_q == S_IDLE && (run || step))
            step_mode_q <= ~run;   // run wins when both are high
         if (state_q == S_WB)
            count_q <= count_q + 16'h0001;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_sel  = 1'b0;
      pc_en     = 1'b0;
      brnch_yes = 1'b0;
      regWE     = 1'b0;
      accWE     = 1'b0;
      memWE     = 1'b0;
      halted    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run || step)
               state_d = S_FETCH;
         end
         S_FETCH: begin
            if (last_wait)
               state_d = S_DECODE;
         end
         S_DECODE: begin
            state_d = (ir_q == HALT_INSTR) ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            state_d = (dec_lw || dec_memWE) ? S_MEM : S_WB;
         end
         S_MEM: begin
            addr_sel = 1'b1;
            // Store issues only on the final MEM cycle, so a reset earlier in MEM drops it.
            memWE    = dec_memWE && last_wait;
            if (last_wait)
               state_d = S_WB;
         end
         S_WB: begin
            regWE     = dec_regWE;
            accWE     = dec_accWE;
            brnch_yes = dec_brnch && acc_zero;
            pc_en     = ~(dec_brnch && acc_zero);
            state_d   = (step_mode_q || !run) ? S_IDLE : S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ir_opcode   = ir_q[7:5];
   assign ir_imm      = ir_q[4:0];
   assign state       = state_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// tb/tb_instr_cycle_sequencer.sv - self-checking bench for instr_cycle_sequencer
module tb_instr_cycle_sequencer;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run, step;
   logic [7:0]  instr_in;
   logic        dec_regWE, dec_accWE, dec_memWE, dec_lw, dec_brnch, acc_zero;
   logic [2:0]  ir_opcode;
   logic [4:0]  ir_imm;
   logic        addr_sel, pc_en, brnch_yes, regWE, accWE, memWE, halted;
   logic [2:0]  state;
   logic [15:0] instr_count;

   int          vec_cnt = 0;
   int          err_cnt = 0;
   logic [15:0] exp_count = 16'h0000;

   instr_cycle_sequencer dut (
      .clk(clk), .rst_n(rst_n), .run(run), .step(step), .instr_in(instr_in),
      .dec_regWE(dec_regWE), .dec_accWE(dec_accWE), .dec_memWE(dec_memWE),
      .dec_lw(dec_lw), .dec_brnch(dec_brnch), .acc_zero(acc_zero),
      .ir_opcode(ir_opcode), .ir_imm(ir_imm), .addr_sel(addr_sel), .pc_en(pc_en),
      .brnch_yes(brnch_yes), .regWE(regWE), .accWE(accWE), .memWE(memWE),
      .halted(halted), .state(state), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // {state, addr_sel, pc_en, brnch_yes, regWE, accWE, memWE, halted}
   function automatic logic [9:0] mkvec(input logic [2:0] s, input logic a, input logic p,
                                        input logic b, input logic r, input logic c,
                                        input logic m, input logic h);
      return {s, a, p, b, r, c, m, h};
   endfunction

   task automatic chk(input string tag, input logic [9:0] exp_v);
      logic [9:0] obs_v;
      obs_v = {state, addr_sel, pc_en, brnch_yes, regWE, accWE, memWE, halted};
      vec_cnt++;
      assert (obs_v === exp_v) else begin
         err_cnt++;
         $error("FAIL %s outputs obs=%b exp=%b", tag, obs_v, exp_v);
      end
      vec_cnt++;
      assert (instr_count === exp_count) else begin
         err_cnt++;
         $error("FAIL %s instr_count obs=%0d exp=%0d", tag, instr_count, exp_count);
      end
   endtask

   task automatic chk_ir(input string tag, input logic [7:0] exp_ir);
      vec_cnt++;
      assert ({ir_opcode, ir_imm} === exp_ir) else begin
         err_cnt++;
         $error("FAIL %s ir obs=%h exp=%h", tag, {ir_opcode, ir_imm}, exp_ir);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         cyc();
         chk("idle", mkvec(3'd0, 0, 0, 0, 0, 0, 0, 0));
      end
   endtask

   // Reference schedule of one instruction: FETCH for W+1 cycles, DECODE, EXEC,
   // MEM for W+1 cycles only for loads/stores, then WB. The caller has already
   // made the IDLE/WB -> FETCH transition pending before calling.
   task automatic run_instr(input logic [7:0] ins, input logic lw, input logic mw,
                            input logic rw, input logic aw, input logic br, input logic az,
                            input bit drop_run, input bit poke_step, input int abort_at);
      logic taken;
      cyc();
      step      = 1'b0;
      dec_lw    = lw;  dec_memWE = mw;  dec_regWE = rw;
      dec_accWE = aw;  dec_brnch = br;  acc_zero  = az;
      for (int i = 0; i <= W; i++) begin
         if (i > 0) cyc();
         instr_in = (i == W) ? ins : 8'($urandom);
         chk("fetch", mkvec(3'd1, 0, 0, 0, 0, 0, 0, 0));
      end
      cyc();
      instr_in = 8'($urandom);
      chk("decode", mkvec(3'd2, 0, 0, 0, 0, 0, 0, 0));
      chk_ir("decode", ins);
      if (drop_run) run = 1'b0;
      if (ins == 8'hFF) return;
      cyc();
      chk("exec", mkvec(3'd3, 0, 0, 0, 0, 0, 0, 0));
      if (poke_step) step = 1'b1;
      if (lw || mw) begin
         for (int i = 0; i <= W; i++) begin
            cyc();
            chk("mem", mkvec(3'd4, 1, 0, 0, 0, 0, mw && (i == W), 0));
            chk_ir("mem", ins);
            if (i == abort_at) begin
               rst_n = 1'b0;
               #1;
               exp_count = 16'h0000;
               chk("async_reset", mkvec(3'd0, 0, 0, 0, 0, 0, 0, 0));
               chk_ir("async_reset", 8'h00);
               return;
            end
         end
      end
      cyc();
      taken = br && az;
      chk("wb", mkvec(3'd5, 0, ~taken, taken, rw, aw, 0, 0));
      chk_ir("wb", ins);
      step = 1'b0;
      exp_count = exp_count + 16'h0001;
   endtask

   initial begin
      logic [7:0] ins;
      bit         drop;
      rst_n = 1'b0; run = 1'b0; step = 1'b0; instr_in = 8'h00;
      dec_regWE = 0; dec_accWE = 0; dec_memWE = 0; dec_lw = 0; dec_brnch = 0; acc_zero = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", mkvec(3'd0, 0, 0, 0, 0, 0, 0, 0));
      chk_ir("reset", 8'h00);
      rst_n = 1'b1;
      idle_cycles(20);

      // ALU op: accWE and pc_en pulse in the 6th cycle
      run = 1'b1;
      run_instr(8'h25, 0, 0, 0, 1, 0, 0, 0, 0, -1);
      // store: addr_sel for 3 cycles, memWE on the last only
      run_instr(8'hA3, 0, 1, 0, 0, 0, 0, 0, 0, -1);
      // load
      run_instr(8'h61, 1, 0, 0, 1, 0, 0, 0, 0, -1);
      // branch taken, then not taken with run falling mid-instruction
      run_instr(8'hC4, 0, 0, 0, 0, 1, 1, 0, 0, -1);
      run_instr(8'hC9, 0, 0, 0, 0, 1, 0, 1, 0, -1);
      idle_cycles(3);

      // single step; a step pulse inside the instruction is ignored
      step = 1'b1;
      run_instr(8'h4E, 0, 0, 1, 0, 0, 0, 0, 1, -1);
      idle_cycles(4);

      // run and step together: run wins, so instructions chain
      run = 1'b1; step = 1'b1;
      run_instr(8'h12, 0, 0, 1, 1, 0, 1, 0, 0, -1);
      run_instr(8'h33, 1, 0, 1, 0, 0, 0, 0, 0, -1);

      // randomized free-run with occasional run drops
      for (int k = 0; k < 30; k++) begin
         ins = 8'($urandom);
         if (ins == 8'hFF) ins = 8'h00;
         drop = ($urandom_range(0, 4) == 0);
         run_instr(ins, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), drop, 0, -1);
         if (drop) begin
            idle_cycles($urandom_range(1, 3));
            run = 1'b1;
         end
      end

      // halt: run/step have no effect afterwards
      run_instr(8'hFF, 0, 0, 1, 1, 0, 0, 0, 0, -1);
      for (int k = 0; k < 10; k++) begin
         run  = 1'($urandom);
         step = 1'($urandom);
         cyc();
         chk("halt", mkvec(3'd6, 0, 0, 0, 0, 0, 0, 1));
         chk_ir("halt", 8'hFF);
      end
      step = 1'b0;
      rst_n = 1'b0;
      #1;
      exp_count = 16'h0000;
      chk("halt_reset", mkvec(3'd0, 0, 0, 0, 0, 0, 0, 0));
      cyc();
      rst_n = 1'b1;
      run   = 1'b1;

      // reset on the 2nd MEM cycle of a store: no memWE ever issues
      run_instr(8'hB7, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      run = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("held_reset", mkvec(3'd0, 0, 0, 0, 0, 0, 0, 0));
      end
      rst_n = 1'b1;
      idle_cycles(3);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
